// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT firing-train sequencer and its helpers.
package ppt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    DONE
  } state_e;

  localparam int CLK_DIV_W = 5;
  localparam int TIME_W    = 14;
  localparam int COUNT_W   = 8;

  // Register-map power-on defaults, used for the shadow copies out of reset.
  localparam int CLK_DIV_DEF = 9;
  localparam int PERIOD_DEF  = 128;
  localparam int WIDTH_DEF   = 1;
  localparam int COUNT_DEF   = 16;

endpackage

// File: rtl/ppt_prescaler.sv
// Time-base divider: one-clock tick every 2^(clk_div+1) clocks, restartable by clear.
module ppt_prescaler
  import ppt_pkg::*;
#(
  parameter int PRESC_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 clear,
  output logic                 tick
);

  logic [PRESC_W-1:0]   cnt;
  logic [PRESC_W-1:0]   terminal;
  logic [CLK_DIV_W-1:0] div_sat;

  // Divider selections beyond the counter width saturate to the longest period.
  always_comb begin
    div_sat = clk_div;
    if (int'(clk_div) > PRESC_W - 2) begin
      div_sat = CLK_DIV_W'(PRESC_W - 2);
    end
    terminal = (PRESC_W'(1) << (div_sat + CLK_DIV_W'(1))) - PRESC_W'(1);
  end

  assign tick = (cnt == terminal) && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || (cnt == terminal)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ppt_pulse_sequencer.sv
// PPT firing-train sequencer: emits count pulses of width ticks every period ticks,
// from a shadow copy of the register-map configuration taken at each run rising edge.
module ppt_pulse_sequencer #(
  parameter int PRESC_W = 32,
  parameter int TIME_W  = ppt_pkg::TIME_W,
  parameter int COUNT_W = ppt_pkg::COUNT_W
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ppt_pkg::CLK_DIV_W-1:0] clk_div,
  input  logic [TIME_W-1:0]             period,
  input  logic [TIME_W-1:0]             width,
  input  logic [COUNT_W-1:0]            count,
  input  logic                          run,
  output logic                          pulse,
  output logic [COUNT_W-1:0]            count_done,
  output logic                          done,
  output logic                          busy
);
  import ppt_pkg::*;

  state_e               state, state_d;
  logic                 run_q;
  logic [CLK_DIV_W-1:0] clk_div_s, clk_div_d;
  logic [TIME_W-1:0]    period_s, period_d;
  logic [TIME_W-1:0]    width_s, width_d;
  logic [COUNT_W-1:0]   count_s, count_d;
  logic [TIME_W-1:0]    tick_cnt, tick_cnt_d;
  logic [COUNT_W-1:0]   count_done_d;
  logic                 pulse_d, done_d, busy_d;

  logic                 start, tick, last_tick;
  logic [TIME_W-1:0]    period_eff, width_eff, tick_next;
  logic [COUNT_W-1:0]   done_inc;

  assign start = run && !run_q;

  // Clamp so every period has at least one low tick; the shadows store the clamped values.
  always_comb begin
    period_eff = (period < TIME_W'(2)) ? TIME_W'(2) : period;
    width_eff  = (width > period_eff - TIME_W'(1)) ? period_eff - TIME_W'(1) : width;
  end

  ppt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .clk_div (clk_div_s),
    .clear   (start && (state == IDLE)),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state;
    clk_div_d    = clk_div_s;
    period_d     = period_s;
    width_d      = width_s;
    count_d      = count_s;
    tick_cnt_d   = tick_cnt;
    count_done_d = count_done;
    pulse_d      = pulse;
    done_d       = done;
    busy_d       = busy;
    last_tick    = (tick_cnt == period_s - TIME_W'(1));
    tick_next    = last_tick ? '0 : tick_cnt + TIME_W'(1);
    done_inc     = count_done + COUNT_W'(1);

    case (state)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          clk_div_d    = clk_div;
          period_d     = period_eff;
          width_d      = width_eff;
          count_d      = count;
          tick_cnt_d   = '0;
          count_done_d = '0;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FIRE;
            busy_d  = 1'b1;
            pulse_d = (width_eff != '0);
          end
        end
      end

      FIRE: begin
        if (tick) begin
          tick_cnt_d = tick_next;
          pulse_d    = (tick_next < width_s);
          if (last_tick) begin
            count_done_d = done_inc;
          end
        end
        // An abort wins over a simultaneous final tick, but the firing is still counted.
        if (!run) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (tick && last_tick && (done_inc == count_s)) begin
          state_d = DONE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (!run) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      clk_div_s  <= CLK_DIV_W'(CLK_DIV_DEF);
      period_s   <= TIME_W'(PERIOD_DEF);
      width_s    <= TIME_W'(WIDTH_DEF);
      count_s    <= COUNT_W'(COUNT_DEF);
      tick_cnt   <= '0;
      count_done <= '0;
      pulse      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      run_q      <= run;
      clk_div_s  <= clk_div_d;
      period_s   <= period_d;
      width_s    <= width_d;
      count_s    <= count_d;
      tick_cnt   <= tick_cnt_d;
      count_done <= count_done_d;
      pulse      <= pulse_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_ppt_pulse_sequencer.sv
// Self-checking bench for ppt_pulse_sequencer: table of trains with a pulse scoreboard,
// plus hand-written abort, abort-on-final-tick and reset-mid-pulse sequences.
module tb_ppt_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  clk_div = '0;
  logic [13:0] period = '0;
  logic [13:0] width = '0;
  logic [7:0]  count = '0;
  logic        run = 1'b0;
  logic        pulse;
  logic [7:0]  count_done;
  logic        done;
  logic        busy;

  always #5 clk = ~clk;

  ppt_pulse_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run        (run),
    .pulse      (pulse),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  typedef struct {
    logic [4:0]  clk_div;
    logic [13:0] period;
    logic [13:0] width;
    logic [7:0]  count;
    int          exp_high;
    int          exp_int;
    int          exp_lat;
    bit          freeze;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   passes = 0;
  int   high_q[$];
  int   int_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: pops an expected high time at each falling edge and an expected
  // rise-to-rise interval at each rise after the first of a train.
  int   ncyc = 0;
  int   last_rise = -1;
  int   high_len = 0;
  logic pulse_prev = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (!busy) last_rise = -1;
    if (pulse && !pulse_prev) begin
      checks++;
      if (high_q.size() > 0) passes++;
      else $display("[TB] FAIL unexpected_pulse: got rise at cycle %0d, expected no pulse", ncyc);
      if (last_rise >= 0 && int_q.size() > 0) check("pulse_interval", ncyc - last_rise, int_q.pop_front());
      last_rise = ncyc;
      high_len  = 0;
    end
    if (pulse) high_len++;
    if (!pulse && pulse_prev && high_q.size() > 0) check("pulse_high", high_len, high_q.pop_front());
    pulse_prev = pulse;
  end

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < int'(v.count); i++) begin
      if (v.exp_high > 0) begin
        high_q.push_back(v.exp_high);
        if (i > 0) int_q.push_back(v.exp_int);
      end
    end
    clk_div = v.clk_div;
    period  = v.period;
    width   = v.width;
    count   = v.count;
    run     = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    while (cyc < v.exp_lat + 40) begin
      @(negedge clk);
      cyc++;
      if (v.freeze && cyc == 3) begin
        period = 14'd10;
        width  = 14'd3;
        count  = 8'd1;
      end
      if (cyc == 1 && v.count != 0) check("busy_during_train", int'(busy), 1);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_latency", seen ? cyc : -1, v.exp_lat);
    check("count_done_final", int'(count_done), int'(v.count));
    check("busy_after_done", int'(busy), 0);
    check("pulse_after_done", int'(pulse), 0);
    check("scoreboard_drained", high_q.size() + int_q.size(), 0);
    repeat (10) @(negedge clk);
    check("done_held", int'(done), 1);
    check("no_retrigger", int'(busy), 0);
    run = 1'b0;
    @(negedge clk);
    check("done_cleared", int'(done), 0);
    check("count_done_kept", int'(count_done), int'(v.count));
  endtask

  initial begin
    vecs[0] = '{5'd0, 14'd4,  14'd1, 8'd3, 2,  8,  25, 1'b1};
    vecs[1] = '{5'd0, 14'd10, 14'd1, 8'd2, 2,  20, 41, 1'b0};
    vecs[2] = '{5'd0, 14'd4,  14'd6, 8'd2, 6,  8,  17, 1'b0};
    vecs[3] = '{5'd0, 14'd0,  14'd5, 8'd2, 2,  4,  9,  1'b0};
    vecs[4] = '{5'd1, 14'd3,  14'd2, 8'd2, 8,  12, 25, 1'b0};
    vecs[5] = '{5'd0, 14'd5,  14'd0, 8'd2, 0,  10, 21, 1'b0};
    vecs[6] = '{5'd2, 14'd2,  14'd1, 8'd1, 8,  16, 17, 1'b0};
    vecs[7] = '{5'd0, 14'd4,  14'd1, 8'd0, 0,  0,  1,  1'b0};
    vecs[8] = '{5'd3, 14'd3,  14'd5, 8'd1, 32, 48, 49, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_pulse", int'(pulse), 0);
    check("reset_busy", int'(busy), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", int'(done), 0);
    check("idle_count_done", int'(count_done), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Abort after the second pulse rises, then restart from a fresh edge.
    high_q.push_back(2);
    high_q.push_back(1);
    int_q.push_back(8);
    clk_div = 5'd0; period = 14'd4; width = 14'd1; count = 8'd10; run = 1'b1;
    repeat (9) @(negedge clk);
    check("abort_second_rise", int'(pulse), 1);
    run = 1'b0;
    @(negedge clk);
    check("abort_pulse", int'(pulse), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_count_done", int'(count_done), 1);
    high_q.push_back(1);
    run = 1'b1;
    @(negedge clk);
    check("restart_count_done", int'(count_done), 0);
    check("restart_busy", int'(busy), 1);
    run = 1'b0;
    @(negedge clk);
    check("restart_abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Run falls in the same clock as the final tick: abort wins, firing still counted.
    high_q.push_back(2);
    clk_div = 5'd0; period = 14'd2; width = 14'd1; count = 8'd1; run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("final_abort_done", int'(done), 0);
    check("final_abort_count_done", int'(count_done), 1);
    check("final_abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset while the second pulse is high.
    high_q.push_back(2);
    high_q.push_back(1);
    int_q.push_back(8);
    clk_div = 5'd0; period = 14'd4; width = 14'd1; count = 8'd3; run = 1'b1;
    repeat (9) @(negedge clk);
    check("pre_reset_pulse", int'(pulse), 1);
    check("pre_reset_count_done", int'(count_done), 1);
    #2;
    rstn = 1'b0;
    run  = 1'b0;
    #1;
    check("async_reset_pulse", int'(pulse), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    check("async_reset_count_done", int'(count_done), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_quiet", int'(pulse) + int'(busy), 0);
    applyStimulus(vecs[6]);
    checkOutput(vecs[6]);

    check("final_scoreboard_empty", high_q.size() + int_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout at %0t, expected test completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
